// File: rtl/sub_serial.sv
// Bit-serial subtractor: out = a - b (mod 2^WIDTH), one bit per clock, LSB first.
// Level-enable start; en low in DONE acknowledges and returns to IDLE.
module sub_serial #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_reg_q, a_reg_d;
    logic [WIDTH-1:0] b_reg_q, b_reg_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    count_q, count_d;
    logic             borrow_q, borrow_d;
    logic             borrow_out_q, borrow_out_d;

    logic             diff_bit;
    logic             borrow_nxt;

    always_comb begin
        diff_bit   = a_reg_q[0] ^ b_reg_q[0] ^ borrow_q;
        borrow_nxt = (~a_reg_q[0] & b_reg_q[0]) | (~(a_reg_q[0] ^ b_reg_q[0]) & borrow_q);

        state_d      = state_q;
        a_reg_d      = a_reg_q;
        b_reg_d      = b_reg_q;
        out_d        = out_q;
        count_d      = count_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    a_reg_d  = a;
                    b_reg_d  = b;
                    borrow_d = 1'b0;
                    count_d  = '0;
                    out_d    = '0;
                    state_d  = SUB;
                end
            end
            SUB: begin
                borrow_d = borrow_nxt;
                out_d    = {diff_bit, out_q[WIDTH-1:1]};
                a_reg_d  = a_reg_q >> 1;
                b_reg_d  = b_reg_q >> 1;
                count_d  = count_q + CW'(1);
                // Final borrow is this cycle's combinational value, not borrow_q.
                if (count_q == LAST) begin
                    state_d      = DONE;
                    borrow_out_d = borrow_nxt;
                end
            end
            DONE: begin
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            a_reg_q      <= '0;
            b_reg_q      <= '0;
            out_q        <= '0;
            count_q      <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_reg_q      <= a_reg_d;
            b_reg_q      <= b_reg_d;
            out_q        <= out_d;
            count_q      <= count_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
        end
    end

    assign out        = out_q;
    assign borrow_out = borrow_out_q;
    assign busy       = (state_q == SUB);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Directed self-checking bench for sub_serial at WIDTH=8.
module tb_sub_serial;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic       borrow_out;
    logic       busy;
    logic       done;

    int n_pass;
    int n_total;

    sub_serial #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .b         (b),
        .out       (out),
        .borrow_out(borrow_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse en for one load edge, then count busy cycles until done (bounded).
    task automatic do_op(input logic [7:0] ai, input logic [7:0] bi,
                         output logic [7:0] r, output logic bo,
                         output int nbusy, output bit got_done);
        @(negedge clk);
        a  = ai;
        b  = bi;
        en = 1'b1;
        @(negedge clk);
        en       = 1'b0;
        nbusy    = 0;
        got_done = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (done) got_done = 1'b1;
            else begin
                if (busy) nbusy++;
                @(negedge clk);
            end
        end
        r  = out;
        bo = borrow_out;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({out, borrow_out, busy, done} !== 11'b0)
            $display("FAIL reset_state out=%h bo=%b busy=%b done=%b, want all 0", out, borrow_out, busy, done);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_idle busy=%b done=%b, want 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_basic;
        logic [7:0] r; logic bo; int nb; bit gd;
        do_op(8'h5A, 8'h23, r, bo, nb, gd);
        n_total++;
        if (!gd || nb != 8)
            $display("FAIL basic_latency busy_cycles=%0d done=%b, want 8 1", nb, gd);
        else n_pass++;
        n_total++;
        if (r !== 8'h37 || bo !== 1'b0)
            $display("FAIL basic_result out=%h bo=%b, want 37 0", r, bo);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || out !== 8'h37)
            $display("FAIL basic_ack done=%b out=%h, want 0 37", done, out);
        else n_pass++;
    endtask

    task automatic test_borrow;
        logic [7:0] r; logic bo; int nb; bit gd;
        do_op(8'h10, 8'h20, r, bo, nb, gd);
        n_total++;
        if (!gd || r !== 8'hF0 || bo !== 1'b1)
            $display("FAIL borrow_set out=%h bo=%b done=%b, want F0 1 1", r, bo, gd);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (borrow_out !== 1'b1)
            $display("FAIL borrow_hold_idle bo=%b, want 1", borrow_out);
        else n_pass++;
        do_op(8'hFF, 8'h01, r, bo, nb, gd);
        n_total++;
        if (!gd || r !== 8'hFE || bo !== 1'b0)
            $display("FAIL borrow_clear out=%h bo=%b done=%b, want FE 0 1", r, bo, gd);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_edges;
        logic [7:0] r; logic bo; int nb; bit gd;
        logic [7:0] va [3] = '{8'h00, 8'h00, 8'h80};
        logic [7:0] vb [3] = '{8'hFF, 8'h00, 8'h80};
        logic [7:0] vr [3] = '{8'h01, 8'h00, 8'h00};
        logic       vbo[3] = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], r, bo, nb, gd);
            n_total++;
            if (!gd || r !== vr[i] || bo !== vbo[i])
                $display("FAIL edge_%0d %h-%h out=%h bo=%b, want %h %b", i, va[i], vb[i], r, bo, vr[i], vbo[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_en_held;
        bit gd;
        int errs;
        @(negedge clk);
        a  = 8'h44;
        b  = 8'h11;
        en = 1'b1;
        gd = 1'b0;
        for (int i = 0; i < 40 && !gd; i++) begin
            @(negedge clk);
            if (done) gd = 1'b1;
        end
        errs = 0;
        for (int i = 0; i < 6; i++) begin
            if (done !== 1'b1 || busy !== 1'b0 || out !== 8'h33) errs++;
            @(negedge clk);
        end
        n_total++;
        if (!gd || errs != 0)
            $display("FAIL en_held_stay done_seen=%b bad_cycles=%0d out=%h, want 1 0 33", gd, errs, out);
        else n_pass++;
        en = 1'b0;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL en_held_release done=%b busy=%b, want 0 0", done, busy);
        else n_pass++;
        a  = 8'h03;
        b  = 8'h01;
        en = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || out !== 8'h00)
            $display("FAIL en_held_reload busy=%b out=%h, want 1 00", busy, out);
        else n_pass++;
        gd = 1'b0;
        for (int i = 0; i < 40 && !gd; i++) begin
            @(negedge clk);
            if (done) gd = 1'b1;
        end
        n_total++;
        if (!gd || out !== 8'h02 || borrow_out !== 1'b0)
            $display("FAIL en_held_second out=%h bo=%b done=%b, want 02 0 1", out, borrow_out, gd);
        else n_pass++;
        en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_noise;
        int nb;
        bit gd;
        @(negedge clk);
        a  = 8'h5A;
        b  = 8'h23;
        en = 1'b1;
        @(negedge clk);
        nb = 0;
        gd = 1'b0;
        for (int i = 0; i < 40 && !gd; i++) begin
            if (done) gd = 1'b1;
            else begin
                if (busy) nb++;
                a  = 8'($urandom);
                b  = 8'($urandom);
                en = ~en;
                @(negedge clk);
            end
        end
        en = 1'b0;
        n_total++;
        if (!gd || nb != 8 || out !== 8'h37 || borrow_out !== 1'b0)
            $display("FAIL noise_during_sub busy_cycles=%0d out=%h bo=%b done=%b, want 8 37 0 1", nb, out, borrow_out, gd);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [7:0] r; logic bo; int nb; bit gd;
        do_op(8'h10, 8'h20, r, bo, nb, gd);
        @(negedge clk);
        a  = 8'h5A;
        b  = 8'h23;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || borrow_out !== 1'b1)
            $display("FAIL reset_mid_pre busy=%b bo=%b, want 1 1", busy, borrow_out);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || borrow_out !== 1'b0)
            $display("FAIL reset_mid_async out=%h busy=%b done=%b bo=%b, want 00 0 0 0", out, busy, done, borrow_out);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_mid_idle busy=%b done=%b, want 0 0", busy, done);
        else n_pass++;
        do_op(8'h5A, 8'h23, r, bo, nb, gd);
        n_total++;
        if (!gd || nb != 8 || r !== 8'h37 || bo !== 1'b0)
            $display("FAIL reset_mid_fresh out=%h bo=%b busy_cycles=%0d, want 37 0 8", r, bo, nb);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_edges();
        test_en_held();
        test_noise();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
Name: sub_serial

Overview:
- Bit-serial subtractor; the complementary datapath to the team's bit-serial adder. Uses the same level-enable start handshake and LSB-first serial shift structure.
- Computes out = a - b (mod 2^WIDTH) one bit per clock. Reports the final borrow on borrow_out.
- Used where area matters more than latency, e.g. decrement/compare paths next to the serial adder.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- CW, $clog2(WIDTH), width of the internal bit counter (derived; not to be overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  level start request; also serves as the done-acknowledge (see Behaviour).
- a  input  WIDTH  minuend; sampled only on the load cycle.
- b  input  WIDTH  subtrahend; sampled only on the load cycle.
- out  output  WIDTH  difference; assembled LSB-first, shifting in at the MSB.
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned). Valid in DONE.
- busy  output  1  high while in SUB.
- done  output  1  high while in DONE.

Behaviour:
- Internal registers:
  - a_reg, b_reg: WIDTH bits each.
  - borrow: 1 bit.
  - count: CW bits.
  - state: IDLE, SUB or DONE.
- Reset (asynchronous, takes effect at any time, including mid-operation):
  - state=IDLE.
  - out=0, borrow_out=0, a_reg=0, b_reg=0, borrow=0, count=0.
  - busy=0, done=0.
- busy and done are decoded directly from state (registered state, no combinational path from en).
- IDLE:
  - If en=1 at an edge: a_reg<=a, b_reg<=b, borrow<=0, count<=0, out<=0, state<=SUB.
  - If en=0: hold all registers. out keeps the previous result.
- SUB, every edge:
  - d = a_reg[0] ^ b_reg[0] ^ borrow.
  - borrow <= (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow).
  - out <= {d, out[WIDTH-1:1]}.
  - a_reg <= a_reg>>1; b_reg <= b_reg>>1.
  - count <= count+1.
  - If count==WIDTH-1: state<=DONE and borrow_out <= the borrow value computed this cycle. count is then don't-care; it is reloaded on the next load.
  - en is ignored in SUB; the operation cannot be aborted except by rst.
  - Changes on a/b during SUB have no effect.
- Latency:
  - Load edge is edge 0. SUB occupies edges 1..WIDTH.
  - done=1 after edge WIDTH (for WIDTH=8: 9 edges after en is sampled).
  - out and borrow_out are final and stable from the first DONE cycle.
- DONE:
  - Hold out and borrow_out.
  - If en=0 at an edge: state<=IDLE.
  - If en=1: remain in DONE. A continuously held en never retriggers; a new operation requires en low for at least one edge, then high.
- borrow_out updates only on SUB→DONE and on reset. It keeps its value through IDLE until the next completion.
- Arithmetic is unsigned, modulo 2^WIDTH. borrow_out=1 exactly when a<b. There is no signed-overflow output.
- count must not wrap before WIDTH-1. For WIDTH a power of two, count wraps to 0 on the terminal cycle, which is harmless.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, en pulsed high one cycle → done after 9 edges, out=0x37, borrow_out=0. busy high for exactly 8 cycles.
- a=0x10, b=0x20 → out=0xF0, borrow_out=1. Then a=0xFF, b=0x01 → out=0xFE, borrow_out=0 (borrow cleared on new load).
- a=0x00, b=0xFF → out=0x01, borrow_out=1. a=0x00, b=0x00 → out=0x00, borrow_out=0. a=0x80, b=0x80 → out=0x00, borrow_out=0.
- en held high continuously from IDLE → one operation only; state stays DONE while en=1. en low one cycle then high → second operation starts, out cleared on load.
- Change a/b every cycle during SUB, and toggle en during SUB → result equals the load-cycle operands; completion still on the 8th SUB cycle.
- Assert rst at the 4th SUB cycle → immediately out=0, busy=0, done=0, borrow_out=0, state IDLE. A fresh en then yields a correct result (0x5A-0x23=0x37).
